demux_n_stream: RTL
===================

# demux_n_stream

Packet-oriented 1-to-2 stream demultiplexer for WIDTH-bit words. It is the receive-side counterpart of the word multiplexers: one upstream valid/ready stream is split into two downstream streams. The destination is chosen per packet, latched on the first beat and held until the last beat. It sits between the coefficient/word datapath and the two consumer buffers of the NTRU-HRSS core. Each output has a 2-entry buffer, so the block sustains one word per clock and has no combinational path from any `outX_ready` to `in_ready`.

## Interface
Parameters:
- WIDTH, 32, data word width
- CNT_W, 16, width of per-port packet counters

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  upstream beat accepted when in_valid & in_ready
- in_data  input  WIDTH  upstream word
- in_last  input  1  final beat of packet
- in_sel  input  1  destination (0 → port 0, 1 → port 1); sampled only on first beat of a packet
- out0_valid / out1_valid  output  1  downstream beat valid
- out0_ready / out1_ready  input  1  downstream accepts beat
- out0_data / out1_data  output  WIDTH  downstream word
- out0_last / out1_last  output  1  final beat of packet
- pkt_cnt0 / pkt_cnt1  output  CNT_W  count of last-beats pushed into each port, wraps modulo 2^CNT_W
- busy  output  1  high while a packet is open (state PKT)

## Operation
- Reset is synchronous and active-low, on `clk` with `rst_n`.
- State machine `st ∈ {IDLE, PKT}` with latched destination register `dst`.
- **Effective destination:**
  - `route = in_sel` in IDLE.
  - `route = dst` in PKT.
- **Ready:** `in_ready = (count[route] < 2)`, where `count[p]` is the occupancy (0..2) of port p's buffer.
  - `in_ready` depends combinationally on `in_sel` in IDLE only. It never depends on `out*_ready`.
- **Accepted beat** (`in_valid & in_ready`): `{in_data, in_last}` is pushed into buffer[route].
- **Transitions:**
  - IDLE, accept with `in_last = 0` → PKT, `dst <= in_sel`.
  - IDLE, accept with `in_last = 1` → stay IDLE (single-beat packet).
  - PKT, accept with `in_last = 1` → IDLE.
  - PKT, otherwise → stay PKT.
  - `in_sel` is ignored in PKT.
- **Counters:** `pkt_cnt[route]` increments by 1 on each accepted beat with `in_last = 1`, wrapping from 2^CNT_W−1 to 0.
- **Buffers:**
  - Each buffer is a 2-entry FIFO with head registers driving `outX_data` and `outX_last`.
  - `outX_valid = (count[X] != 0)`.
  - Pop on `outX_valid & outX_ready`.
  - Push and pop in the same cycle leave `count` unchanged and preserve order.
- **Ports are independent:**
  - Port 1 may drain while port 0 stalls and vice versa.
  - A stalled port blocks only packets routed to it.
- **Data integrity:** words are never dropped, duplicated or reordered within a port.
- `outX_data` is don't-care while `outX_valid = 0`, but must hold stable while `outX_valid = 1` and `outX_ready = 0`.
- `in_valid` without `in_ready` has no effect: no state change and no counter change.

## Timing
- **Reset values:**
  - st = IDLE, dst = 0, both counts = 0.
  - out0_valid = out1_valid = 0, out0_last = out1_last = 0, out0_data = out1_data = 0.
  - pkt_cnt0 = pkt_cnt1 = 0, busy = 0.
  - in_ready follows the combinational rule (1 after reset).
- Reset asserted mid-packet flushes both buffers and returns to IDLE in the same edge. Partially delivered packets are discarded and not counted.
- **Latency:** a beat accepted at edge n is visible on `outX_valid`/`outX_data` after edge n (one cycle).
- **Throughput:** one beat per cycle per stream while the destination's `outX_ready` is held high.
- **Full buffer:**
  - `count = 2` forces `in_ready = 0` for that route, even if the destination pops in the same cycle.
  - `in_ready` rises the cycle after the pop.
  - With `outX_ready` held high, the buffer never exceeds 1 entry, so no bubbles occur.
- **Destination switch:** back-to-back packets to different ports may be accepted on consecutive cycles, so zero idle cycles are needed between the last beat and the next first beat.
- `busy` is registered: high the cycle after a non-last first beat, low the cycle after the last beat.

## Test plan
- **Reset:** hold rst_n = 0 for 3 cycles with in_valid = 1 → all outputs at reset values, no pushes. Release → in_ready = 1.
- **Single packets:**
  - Send a 4-beat packet (0x11, 0x22, 0x33, 0x44) with in_sel = 1 on beat 0 and in_sel toggling on later beats, out1_ready = 1 → port 1 emits all 4 words in order, one cycle after each accept, last on 0x44.
  - Port 0 stays idle throughout; pkt_cnt1 = 1, pkt_cnt0 = 0.
- **Backpressure:** out0_ready = 0 while sending a 5-beat packet to port 0 → 2 beats accepted, then in_ready = 0. Raise out0_ready → remaining 3 beats flow, all 5 words delivered in order with none lost.
- **Independence:** port 0 stalled and full, then send a 1-beat packet (in_last = 1) with in_sel = 1 → accepted immediately and delivered on port 1 the next cycle; pkt_cnt1 increments.
- **Back-to-back switching:** alternating 2-beat packets 0 → 1 → 0, both readys high → in_ready held high on all 6 cycles, and each port sees its words at one-cycle latency. Also apply 2^CNT_W single-beat packets to port 0 → pkt_cnt0 wraps to 0.
- **Reset mid-packet:** assert rst_n = 0 after beat 2 of a 4-beat packet with 1 word buffered → buffers empty, busy = 0, counters 0. The next packet is routed by its own in_sel.

Source files
------------

// File: rtl/demux_n_stream_if.sv
// demux_n_stream_if: word stream bundle (valid/ready/data/last plus per-packet select)
interface demux_n_stream_if #(parameter int WIDTH = 32);
    logic             valid;
    logic             ready;
    logic             last;
    logic             sel;
    logic [WIDTH-1:0] data;
    modport master (output valid, data, last, sel, input ready);
    modport slave (input valid, data, last, sel, output ready);
endinterface

// File: rtl/demux_n_stream.sv
// demux_n_stream: packet-routed 1-to-2 stream demux with a 2-entry buffer per output
module demux_n_stream_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             lin,
    input  logic [WIDTH-1:0] din,
    input  logic             rdy,
    output logic             full,
    output logic             valid,
    output logic             last,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] pc
);
    logic [1:0]       cnt;
    logic [WIDTH-1:0] td;
    logic             tl;
    logic             pop;
    assign valid = cnt != 2'd0;
    assign full  = cnt == 2'd2;
    assign pop   = valid & rdy;
    // data/last form the head entry; td/tl hold the second word while the head stalls
    always_ff @(posedge clk)
        if (!rst_n) begin
            cnt  <= 2'd0;
            data <= '0;
            last <= 1'b0;
            td   <= '0;
            tl   <= 1'b0;
            pc   <= '0;
        end else begin
            cnt <= cnt + 2'(push) - 2'(pop);
            if (push && lin) pc <= pc + CNT_W'(1);
            if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) begin
                data <= din;
                last <= lin;
            end else if (pop) begin
                data <= td;
                last <= tl;
            end
            if (push && cnt == 2'd1 && !pop) begin
                td <= din;
                tl <= lin;
            end
        end
endmodule

module demux_n_stream #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    demux_n_stream_if.slave    in,
    demux_n_stream_if.master   out0,
    demux_n_stream_if.master   out1,
    output logic [CNT_W-1:0]   pkt_cnt0,
    output logic [CNT_W-1:0]   pkt_cnt1,
    output logic               busy
);
    typedef enum logic {IDLE, PKT} st_t;
    st_t  st, st_nx;
    logic dst, route, acc, full0, full1;
    // ready looks only at buffer occupancy, so no path from out*_ready reaches in_ready
    assign route     = (st == PKT) ? dst : in.sel;
    assign in.ready  = route ? !full1 : !full0;
    assign acc       = in.valid & in.ready;
    assign busy      = st == PKT;
    assign out0.sel  = 1'b0;
    assign out1.sel  = 1'b0;
    always_comb begin
        st_nx = st;
        st_nx = acc ? (in.last ? IDLE : PKT) : st;
    end
    always_ff @(posedge clk)
        if (!rst_n) begin
            st  <= IDLE;
            dst <= 1'b0;
        end else begin
            st <= st_nx;
            if (acc && st == IDLE) dst <= in.sel;
        end
    demux_n_stream_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_buf0 (
        .clk(clk), .rst_n(rst_n), .push(acc & !route), .lin(in.last), .din(in.data),
        .rdy(out0.ready), .full(full0), .valid(out0.valid), .last(out0.last),
        .data(out0.data), .pc(pkt_cnt0)
    );
    demux_n_stream_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_buf1 (
        .clk(clk), .rst_n(rst_n), .push(acc & route), .lin(in.last), .din(in.data),
        .rdy(out1.ready), .full(full1), .valid(out1.valid), .last(out1.last),
        .data(out1.data), .pc(pkt_cnt1)
    );
endmodule
